// File: rtl/ts_pulse_generator.sv
// Scheduled pulse generator: fires one pulse per queued (utc, coarse) timestamp
// when the local time counter reaches it; frac is passed through to the delay line.
module ts_pulse_generator #(
    parameter int g_frac_bits    = 12,
    parameter int g_coarse_range = 125000000,
    parameter int g_fifo_depth   = 4,
    parameter int g_pulse_width  = 3
) (
    input  logic                                clk_ref_i,
    input  logic                                rst_i,
    input  logic                                enable_i,
    input  logic [31:0]                         csync_utc_i,
    input  logic [27:0]                         csync_coarse_i,
    input  logic                                csync_p1_i,
    input  logic                                sched_valid_i,
    output logic                                sched_ready_o,
    input  logic [31:0]                         sched_utc_i,
    input  logic [27:0]                         sched_coarse_i,
    input  logic [g_frac_bits-1:0]              sched_frac_i,
    output logic                                pulse_o,
    output logic [g_frac_bits-1:0]              pulse_frac_o,
    output logic                                fire_p1_o,
    output logic                                miss_p1_o,
    output logic [$clog2(g_fifo_depth):0]       fifo_count_o,
    output logic [31:0]                         cntr_utc_o,
    output logic [27:0]                         cntr_coarse_o
);

    localparam int AW   = (g_fifo_depth > 1) ? $clog2(g_fifo_depth) : 1;
    localparam int CW   = $clog2(g_fifo_depth) + 1;
    localparam int PW_W = (g_pulse_width > 1) ? $clog2(g_pulse_width) : 1;
    localparam int EW   = 32 + 28 + g_frac_bits;

    localparam logic [27:0]   COARSE_LAST = 28'(g_coarse_range - 1);
    localparam logic [CW-1:0] DEPTH       = CW'(g_fifo_depth);
    localparam logic [PW_W-1:0] PW_LOAD   = PW_W'(g_pulse_width - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_PULSE
    } state_t;

    state_t state, state_nxt;

    logic [EW-1:0]   mem [g_fifo_depth];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_nxt;
    logic [PW_W-1:0] pw_cnt;

    logic                   push, pop;
    logic                   do_fire, do_miss, pulse_end;
    logic                   head_eq, head_lt;
    logic [31:0]            head_utc;
    logic [27:0]            head_coarse;
    logic [g_frac_bits-1:0] head_frac;

    // Time counter: csync load has priority, then second wrap, then increment.
    always_ff @(posedge clk_ref_i) begin
        if (rst_i) begin
            cntr_utc_o    <= '0;
            cntr_coarse_o <= '0;
        end else if (csync_p1_i) begin
            if (csync_coarse_i == COARSE_LAST) begin
                cntr_coarse_o <= '0;
                cntr_utc_o    <= csync_utc_i + 32'd1;
            end else begin
                cntr_coarse_o <= csync_coarse_i + 28'd1;
                cntr_utc_o    <= csync_utc_i;
            end
        end else if (cntr_coarse_o >= COARSE_LAST) begin
            cntr_coarse_o <= '0;
            cntr_utc_o    <= cntr_utc_o + 32'd1;
        end else begin
            cntr_coarse_o <= cntr_coarse_o + 28'd1;
        end
    end

    assign sched_ready_o = enable_i && !rst_i && (count < DEPTH);
    assign fifo_count_o  = count;

    // Schedule storage carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk_ref_i) begin
        if (push) begin
            mem[wr_ptr] <= {sched_utc_i, sched_coarse_i, sched_frac_i};
        end
    end

    assign {head_utc, head_coarse, head_frac} = mem[rd_ptr];
    assign head_eq = ({head_utc, head_coarse} == {cntr_utc_o, cntr_coarse_o});
    assign head_lt = ({head_utc, head_coarse} <  {cntr_utc_o, cntr_coarse_o});

    always_ff @(posedge clk_ref_i) begin
        if (rst_i || !enable_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
        end
    end

    // Next-state decisions use the post-push/pop occupancy so a freshly
    // written entry is compared on the very next cycle.
    always_comb begin
        push      = sched_valid_i && sched_ready_o;
        pop       = 1'b0;
        do_fire   = 1'b0;
        do_miss   = 1'b0;
        pulse_end = 1'b0;
        state_nxt = state;

        case (state)
            ST_ARMED: begin
                if (enable_i && count != '0) begin
                    if (head_eq) begin
                        do_fire = 1'b1;
                        pop     = 1'b1;
                    end else if (head_lt) begin
                        do_miss = 1'b1;
                        pop     = 1'b1;
                    end
                end
            end
            ST_PULSE: pulse_end = (pw_cnt == '0);
            default: ;
        endcase

        count_nxt = count + CW'(push) - CW'(pop);

        case (state)
            ST_IDLE: begin
                if (count_nxt != '0) state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (do_fire)                state_nxt = ST_PULSE;
                else if (count_nxt == '0)   state_nxt = ST_IDLE;
            end
            ST_PULSE: begin
                if (pulse_end) state_nxt = (count_nxt != '0) ? ST_ARMED : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (!enable_i) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk_ref_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Output stage: pulse held for g_pulse_width cycles by a down-counter.
    always_ff @(posedge clk_ref_i) begin
        if (rst_i) begin
            pulse_o      <= 1'b0;
            pulse_frac_o <= '0;
            fire_p1_o    <= 1'b0;
            miss_p1_o    <= 1'b0;
            pw_cnt       <= '0;
        end else if (!enable_i) begin
            pulse_o   <= 1'b0;
            fire_p1_o <= 1'b0;
            miss_p1_o <= 1'b0;
            pw_cnt    <= '0;
        end else begin
            fire_p1_o <= do_fire;
            miss_p1_o <= do_miss;
            if (do_fire) begin
                pulse_o      <= 1'b1;
                pulse_frac_o <= head_frac;
                pw_cnt       <= PW_LOAD;
            end else if (state == ST_PULSE) begin
                if (pulse_end) pulse_o <= 1'b0;
                else           pw_cnt  <= pw_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ts_pulse_generator.sv
// Bench for ts_pulse_generator: directed scenarios plus randomized traffic,
// all checked every cycle against a timestamp-queue model of the channel.
module tb_ts_pulse_generator;

    localparam int FB = 12;
    localparam int R  = 125000000;
    localparam int D  = 4;
    localparam int PW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b1;
    logic [31:0]   csync_utc = '0;
    logic [27:0]   csync_coarse = '0;
    logic          csync_p1 = 1'b0;
    logic          sched_valid = 1'b0;
    logic          sched_ready;
    logic [31:0]   sched_utc = '0;
    logic [27:0]   sched_coarse = '0;
    logic [FB-1:0] sched_frac = '0;
    logic          pulse;
    logic [FB-1:0] pulse_frac;
    logic          fire_p1;
    logic          miss_p1;
    logic [$clog2(D):0] fifo_count;
    logic [31:0]   cntr_utc;
    logic [27:0]   cntr_coarse;

    ts_pulse_generator #(
        .g_frac_bits(FB), .g_coarse_range(R), .g_fifo_depth(D), .g_pulse_width(PW)
    ) dut (
        .clk_ref_i(clk), .rst_i(rst), .enable_i(enable),
        .csync_utc_i(csync_utc), .csync_coarse_i(csync_coarse), .csync_p1_i(csync_p1),
        .sched_valid_i(sched_valid), .sched_ready_o(sched_ready),
        .sched_utc_i(sched_utc), .sched_coarse_i(sched_coarse), .sched_frac_i(sched_frac),
        .pulse_o(pulse), .pulse_frac_o(pulse_frac), .fire_p1_o(fire_p1), .miss_p1_o(miss_p1),
        .fifo_count_o(fifo_count), .cntr_utc_o(cntr_utc), .cntr_coarse_o(cntr_coarse)
    );

    always #4 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int nfire = 0;
    int nmiss = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of pending timestamps, a remaining-high-time count for the
    // pulse, and the local time as plain (utc, coarse) numbers.
    typedef struct {
        logic [31:0]   utc;
        logic [27:0]   coarse;
        logic [FB-1:0] frac;
    } ent_t;

    ent_t          mq[$];
    logic [31:0]   m_utc = '0;
    logic [27:0]   m_coarse = '0;
    int            m_left = 0;
    logic [FB-1:0] m_frac = '0;
    bit            m_fire = 0;
    bit            m_miss = 0;
    bit            started = 0;
    bit            m_acc;
    longint        t_now, t_head;
    ent_t          m_e;

    always @(posedge clk) begin
        started = 1;
        m_fire  = 0;
        m_miss  = 0;
        if (rst) begin
            mq.delete();
            m_left   = 0;
            m_frac   = '0;
            m_utc    = '0;
            m_coarse = '0;
        end else begin
            m_acc = sched_valid && enable && (mq.size() < D);
            if (!enable) begin
                mq.delete();
                m_left = 0;
            end else begin
                if (m_left > 0) begin
                    m_left--;
                end else if (mq.size() > 0) begin
                    t_now  = longint'(m_utc) * R + longint'(m_coarse);
                    t_head = longint'(mq[0].utc) * R + longint'(mq[0].coarse);
                    if (t_head == t_now) begin
                        m_fire = 1;
                        m_frac = mq[0].frac;
                        m_left = PW;
                        void'(mq.pop_front());
                    end else if (t_head < t_now) begin
                        m_miss = 1;
                        void'(mq.pop_front());
                    end
                end
                if (m_acc) begin
                    m_e.utc = sched_utc; m_e.coarse = sched_coarse; m_e.frac = sched_frac;
                    mq.push_back(m_e);
                end
            end
            if (csync_p1) begin
                if (csync_coarse == 28'(R - 1)) begin
                    m_coarse = '0;
                    m_utc    = csync_utc + 32'd1;
                end else begin
                    m_coarse = csync_coarse + 28'd1;
                    m_utc    = csync_utc;
                end
            end else if (m_coarse >= 28'(R - 1)) begin
                m_coarse = '0;
                m_utc    = m_utc + 32'd1;
            end else begin
                m_coarse = m_coarse + 28'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("pulse_o", pulse, (m_left > 0));
            chk("pulse_frac_o", pulse_frac, m_frac);
            chk("fire_p1_o", fire_p1, m_fire);
            chk("miss_p1_o", miss_p1, m_miss);
            chk("fifo_count_o", fifo_count, mq.size());
            chk("sched_ready_o", sched_ready, enable && !rst && (mq.size() < D));
            chk("cntr_utc_o", cntr_utc, m_utc);
            chk("cntr_coarse_o", cntr_coarse, m_coarse);
            chk("fire_miss_exclusive", fire_p1 && miss_p1, 0);
            if (fire_p1) nfire++;
            if (miss_p1) nmiss++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_csync(input logic [31:0] u, input logic [27:0] c);
        csync_utc = u; csync_coarse = c; csync_p1 = 1'b1;
        tick();
        csync_p1 = 1'b0;
    endtask

    task automatic push_entry(input logic [31:0] u, input logic [27:0] c, input logic [FB-1:0] f);
        int n = 0;
        sched_utc = u; sched_coarse = c; sched_frac = f; sched_valid = 1'b1;
        while (!sched_ready && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) chk("push_timeout", 0, 1);
        tick();
        sched_valid = 1'b0;
    endtask

    task automatic wait_cntr(input logic [31:0] u, input logic [27:0] c, input int max);
        int n = 0;
        while (!(cntr_utc == u && cntr_coarse == c) && n < max) begin
            tick();
            n++;
        end
        if (n >= max) chk("wait_cntr_timeout", 0, 1);
    endtask

    task automatic wait_fire(input int max);
        int n = 0;
        while (!fire_p1 && n < max) begin
            tick();
            n++;
        end
        if (n >= max) chk("wait_fire_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int f0, m0;
    longint t;

    initial begin
        repeat (3) tick();
        chk("reset_pulse", pulse, 0);
        chk("reset_count", fifo_count, 0);
        chk("reset_ready", sched_ready, 0);
        chk("reset_utc", cntr_utc, 0);
        rst = 1'b0;
        tick();

        // Normal fire in the future
        do_csync(32'd5, 28'd100);
        push_entry(32'd5, 28'd200, 12'h7A3);
        chk("s1_count_after_push", fifo_count, 1);
        wait_cntr(32'd5, 28'd200, 300);
        tick();
        chk("s1_pulse_rise", pulse, 1);
        chk("s1_fire", fire_p1, 1);
        chk("s1_frac", pulse_frac, 12'h7A3);
        chk("s1_count_after_fire", fifo_count, 0);
        tick(); chk("s1_pulse_c2", pulse, 1); chk("s1_fire_once", fire_p1, 0);
        tick(); chk("s1_pulse_c3", pulse, 1);
        tick(); chk("s1_pulse_end", pulse, 0);
        repeat (3) tick();

        // Second wrap
        do_csync(32'd9, 28'd124999997);
        chk("s2_coarse_pre", cntr_coarse, 124999998);
        sched_utc = 32'd10; sched_coarse = 28'd0; sched_frac = 12'h000; sched_valid = 1'b1;
        tick();
        sched_valid = 1'b0;
        chk("s2_coarse_last", cntr_coarse, 124999999);
        tick();
        chk("s2_utc_wrap", cntr_utc, 10);
        chk("s2_coarse_wrap", cntr_coarse, 0);
        chk("s2_no_pulse_yet", pulse, 0);
        tick();
        chk("s2_fire", fire_p1, 1);
        chk("s2_pulse", pulse, 1);
        repeat (5) tick();

        // Late entry
        do_csync(32'd3, 28'd999);
        f0 = nfire; m0 = nmiss;
        push_entry(32'd3, 28'd500, 12'h055);
        tick();
        chk("s3_miss", miss_p1, 1);
        chk("s3_no_pulse", pulse, 0);
        chk("s3_fifo_empty", fifo_count, 0);
        tick();
        chk("s3_miss_once", nmiss - m0, 1);
        chk("s3_no_fire", nfire - f0, 0);

        // Back-to-back schedule and overflow
        do_csync(32'd1, 28'd49);
        f0 = nfire; m0 = nmiss;
        push_entry(32'd1, 28'd100, 12'h100);
        push_entry(32'd1, 28'd101, 12'h101);
        push_entry(32'd1, 28'd110, 12'h110);
        push_entry(32'd1, 28'd120, 12'h120);
        sched_utc = 32'd1; sched_coarse = 28'd130; sched_frac = 12'h130; sched_valid = 1'b1;
        chk("s4_ready_full", sched_ready, 0);
        chk("s4_count_full", fifo_count, 4);
        tick();
        chk("s4_count_held", fifo_count, 4);
        push_entry(32'd1, 28'd130, 12'h130);
        wait_cntr(32'd1, 28'd140, 300);
        chk("s4_fires", nfire - f0, 4);
        chk("s4_misses", nmiss - m0, 1);
        chk("s4_last_frac", pulse_frac, 12'h130);

        // csync jump
        do_csync(32'd1, 28'd0);
        f0 = nfire; m0 = nmiss;
        push_entry(32'd2, 28'd50, 12'h250);
        push_entry(32'd4, 28'd50, 12'h450);
        do_csync(32'd3, 28'd0);
        repeat (3) tick();
        chk("s5_past_missed", nmiss - m0, 1);
        chk("s5_no_fire_yet", nfire - f0, 0);
        chk("s5_future_waits", fifo_count, 1);
        do_csync(32'd3, 28'd124999995);
        wait_cntr(32'd4, 28'd60, 300);
        chk("s5_future_fired", nfire - f0, 1);
        chk("s5_frac", pulse_frac, 12'h450);
        do_csync(32'd7, 28'd124999999);
        chk("s5_csync_wrap_utc", cntr_utc, 8);
        chk("s5_csync_wrap_coarse", cntr_coarse, 0);

        // enable drop mid-pulse
        do_csync(32'd6, 28'd0);
        push_entry(32'd6, 28'd20, 12'h620);
        push_entry(32'd6, 28'd30, 12'h630);
        push_entry(32'd6, 28'd40, 12'h640);
        wait_fire(100);
        tick();
        chk("s6_pulse_c2", pulse, 1);
        m0 = nmiss;
        enable = 1'b0;
        tick();
        chk("s6_pulse_off", pulse, 0);
        chk("s6_flushed", fifo_count, 0);
        chk("s6_no_miss", miss_p1, 0);
        repeat (3) tick();
        chk("s6_no_miss_later", nmiss - m0, 0);
        enable = 1'b1;
        tick();

        // reset mid-pulse
        do_csync(32'd6, 28'd100);
        push_entry(32'd6, 28'd120, 12'hABC);
        push_entry(32'd6, 28'd130, 12'h631);
        push_entry(32'd6, 28'd140, 12'h641);
        wait_fire(100);
        tick();
        rst = 1'b1;
        tick();
        chk("s7_pulse", pulse, 0);
        chk("s7_frac", pulse_frac, 0);
        chk("s7_count", fifo_count, 0);
        chk("s7_utc", cntr_utc, 0);
        chk("s7_coarse", cntr_coarse, 0);
        chk("s7_ready", sched_ready, 0);
        rst = 1'b0;
        tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            csync_p1 = ($urandom_range(0, 99) < 2);
            csync_utc = 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) csync_coarse = 28'($urandom_range(0, R - 1));
            else                          csync_coarse = 28'(R - 1 - $urandom_range(0, 20));
            enable = ($urandom_range(0, 199) != 0);
            sched_valid = ($urandom_range(0, 2) == 0);
            t = longint'(m_utc) * R + longint'(m_coarse) + longint'($urandom_range(0, 60)) - 12;
            if (t < 0) t = 0;
            sched_utc    = 32'(t / R);
            sched_coarse = 28'(t % R);
            sched_frac   = FB'($urandom);
            tick();
        end
        csync_p1 = 1'b0;
        sched_valid = 1'b0;
        enable = 1'b1;
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ts_pulse_generator.md
Name: ts_pulse_generator

Overview:
- Transmit-side counterpart of the trigger timestamper: takes absolute timestamps (UTC, coarse, frac) from a small schedule FIFO and emits one output pulse per timestamp when the local time counter reaches it.
- Frac is not resolved here. It is forwarded with the pulse to the fine delay line driver.
- Sits between the channel's schedule source (software/CSR or loopback from the timestamper) and the delay-line output stage.
- The local time counter is kept coherent with the timestamper through the same csync interface.

Parameters:
- g_frac_bits, 12, width of the fine (sub-cycle) field.
- g_coarse_range, 125000000, coarse cycles per UTC second.
- g_fifo_depth, 4, schedule FIFO entries; must be a power of 2, minimum 2.
- g_pulse_width, 3, pulse_o high time in clk_ref_i cycles; minimum 1.

Ports:
- clk_ref_i  in  1  reference clock (8 ns).
- rst_i  in  1  synchronous reset, active-high.
- enable_i  in  1  channel enable; low flushes the schedule and aborts any pulse.
- csync_utc_i  in  32  UTC value to load on csync.
- csync_coarse_i  in  28  coarse value to load on csync.
- csync_p1_i  in  1  single-cycle strobe to load the counter.
- sched_valid_i  in  1  schedule entry valid.
- sched_ready_o  out  1  FIFO can accept an entry.
- sched_utc_i  in  32  scheduled UTC.
- sched_coarse_i  in  28  scheduled coarse; values ≥ g_coarse_range are illegal.
- sched_frac_i  in  g_frac_bits  scheduled frac.
- pulse_o  out  1  output pulse.
- pulse_frac_o  out  g_frac_bits  frac of the current/last pulse; held until the next fire.
- fire_p1_o  out  1  one-cycle strobe on the pulse rising edge.
- miss_p1_o  out  1  one-cycle strobe when an entry is discarded as late.
- fifo_count_o  out  clog2(g_fifo_depth)+1  current FIFO occupancy.
- cntr_utc_o  out  32  local UTC counter.
- cntr_coarse_o  out  28  local coarse counter.

Behaviour:
- Reset (rst_i high at a clock edge) clears the following: all counters 0, FIFO empty, pulse_o 0, pulse_frac_o 0, fire_p1_o 0, miss_p1_o 0, FSM in IDLE. sched_ready_o is 0 during reset.
- Reset mid-pulse: pulse_o is 0 on the cycle after the reset edge.
- Time counter, priority order:
  - csync_p1_i: load coarse = csync_coarse_i+1, utc = csync_utc_i. If csync_coarse_i == g_coarse_range-1, load coarse 0 and utc csync_utc_i+1.
  - Else if coarse ≥ g_coarse_range-1: coarse 0, utc+1.
  - Else coarse+1.
  - The counter runs regardless of enable_i.
- FIFO:
  - Accept on sched_valid_i && sched_ready_o.
  - sched_ready_o = enable_i && count < g_fifo_depth, registered-free (combinational from count).
  - Push while full is never accepted, even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle leave the count unchanged.
  - An entry written at cycle N is visible at the head from cycle N+1.
- Time compare: each cycle the head (utc, coarse) is compared lexicographically against the current counter value (utc first, then coarse).
- FSM:
  - IDLE, FIFO empty or enable_i low. Go to ARMED when count > 0 and enable_i.
  - ARMED, head is compared each cycle:
    - Head == counter: next edge sets pulse_o=1, fire_p1_o=1, pulse_frac_o=head.frac, pops the head, goes to PULSE.
    - Head < counter (late): next edge sets miss_p1_o=1 and pops, with no pulse. Stay ARMED if entries remain, else IDLE.
    - Head > counter: wait.
  - PULSE: hold pulse_o for exactly g_pulse_width cycles via a down-counter, then pulse_o=0. Go to ARMED if count > 0, else IDLE.
    - The head is not evaluated during PULSE. A head whose time passes during PULSE becomes a miss on return to ARMED.
- Latency: the pulse_o rising edge is exactly 1 clk_ref_i cycle after the cycle where the counter equals the scheduled (utc, coarse). This constant is compensated downstream.
- Minimum lead: an entry accepted at cycle N fires only if its time ≥ the counter value at N+1. Otherwise it is a miss.
- csync jump: a jump only affects the comparison. Entries now in the past are missed one per cycle; entries now in the future wait.
- UTC rollover: 0xFFFFFFFF→0 is treated as ordinary unsigned compare (no wrap-aware ordering).
- enable_i low: on the next edge the FIFO is flushed, pulse_o=0, the FSM goes to IDLE, and no miss strobes are generated for flushed entries.
- fire_p1_o and miss_p1_o are never high in the same cycle.

Test Plan:
- Schedule in the future, normal fire:
  - Stimulus: csync load utc=5, coarse=100. Schedule (5, 200, frac=0x7A3).
  - Required: pulse_o rises on the cycle after cntr=(5,200) and lasts 3 cycles; pulse_frac_o=0x7A3; fire_p1_o once; fifo_count_o 1→0.
- Second wrap:
  - Stimulus: counter at (9, 124999998); schedule (10, 0, 0).
  - Required: counter goes 124999999 → (10, 0); pulse fires one cycle after (10, 0).
- Late entry:
  - Stimulus: counter at (3, 1000); schedule (3, 500).
  - Required: miss_p1_o pulses once; no pulse_o; FIFO empty.
- Back-to-back schedule and overflow:
  - Stimulus: schedule 5 entries at (1,100), (1,101), (1,110), (1,120), (1,130).
  - Required: sched_ready_o low after 4 entries, so the 5th is held. (1,101) falls inside the (1,100) pulse and is reported as a miss. (1,110) fires.
- csync jump:
  - Stimulus: entries (2,50) and (4,50) queued; csync_p1 loads utc=3, coarse=0.
  - Required: (2,50) is missed; (4,50) fires. Also, csync_coarse_i=124999999 with utc=7 loads counter (8, 0).
- enable/reset mid-pulse:
  - Stimulus: drop enable_i in the 2nd pulse cycle with 2 entries queued.
  - Required: pulse_o=0 next cycle; fifo_count_o=0; no miss_p1_o.
  - Repeat with rst_i instead: all outputs return to reset values.
